// File: rtl/redmule_pkg.sv
// RedMulE shared types: Z buffer flags and Z buffer control states.
// Imported by the Z buffer control slice.
package redmule_pkg;

    typedef struct packed {
        logic full;
        logic empty;
    } z_buffer_flgs_t;

    typedef enum logic [1:0] {
        FILL,
        FULL,
        DRAIN,
        DONE
    } zbuf_state_e;

endpackage

// File: rtl/redmule_zbuf_mem.sv
// Z buffer storage: flop array, one write port, one registered read port.
// Array contents are not reset; only the read register is.
module redmule_zbuf_mem #(
    parameter int unsigned Width = 8,
    parameter int unsigned RowW  = 64,
    parameter int unsigned AW    = $clog2(Width)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [RowW-1:0] wdata_i,
    input  logic            re_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [RowW-1:0] rdata_o
);

    logic [RowW-1:0] mem_q [Width];
    logic [RowW-1:0] rdata_q;

    // Row write from the engine.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; holds its value when no read is requested.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (clear_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/redmule_zbuf_ctrl.sv
// Z output buffer control: fills rows from the engine, then drains the
// tile to the Z streamer over valid/ready and pulses empty when done.
module redmule_zbuf_ctrl
    import redmule_pkg::*;
#(
    parameter int unsigned Width  = 8,
    parameter int unsigned Height = 4,
    parameter int unsigned DW     = 16,
    parameter int unsigned CW     = $clog2(Width + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 clk_en_i,
    input  logic                 fill_i,
    input  logic [Height*DW-1:0] fill_data_i,
    input  logic [CW-1:0]        rows_i,
    input  logic                 storing_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [Height*DW-1:0] out_data_o,
    output logic                 out_last_o,
    output z_buffer_flgs_t       flgs_o,
    output logic                 overflow_o
);

    localparam int unsigned AW   = $clog2(Width);
    localparam int unsigned RowW = Height * DW;

    zbuf_state_e   state_q;
    logic [CW-1:0] wr_cnt_q;
    logic [CW-1:0] rd_cnt_q;
    logic [CW-1:0] lim_q;
    logic          full_q;
    logic          empty_q;
    logic          valid_q;
    logic          last_q;
    logic          ovf_q;

    logic [CW-1:0] rows_eff;
    logic [CW-1:0] lim_cur;
    logic          fill_acc;
    logic          we;
    logic          rd_start;
    logic          rd_adv;
    logic          re;
    logic [AW-1:0] raddr;

    // Out-of-range row counts mean a full tile.
    assign rows_eff = (rows_i == '0 || rows_i > CW'(Width))
                    ? CW'(Width) : rows_i;
    // The first write of a tile sees rows_i directly.
    assign lim_cur  = (wr_cnt_q == '0) ? rows_eff : lim_q;
    assign fill_acc = fill_i & clk_en_i;
    assign we       = fill_acc & (state_q == FILL) & ~clear_i;
    assign rd_start = (state_q == FULL) & storing_i;
    assign rd_adv   = (state_q == DRAIN) & out_ready_i & ~last_q;
    assign re       = rd_start | rd_adv;
    assign raddr    = rd_start ? '0 : AW'(rd_cnt_q + CW'(1));

    redmule_zbuf_mem #(
        .Width (Width),
        .RowW  (RowW)
    ) i_mem (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .we_i    (we),
        .waddr_i (wr_cnt_q[AW-1:0]),
        .wdata_i (fill_data_i),
        .re_i    (re),
        .raddr_i (raddr),
        .rdata_o (out_data_o)
    );

    // Tile FSM, counters and registered flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= FILL;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            lim_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (clear_i) begin
            state_q  <= FILL;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            lim_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            ovf_q <= fill_acc & (state_q != FILL);
            unique case (state_q)
                FILL: begin
                    if (fill_acc) begin
                        wr_cnt_q <= wr_cnt_q + CW'(1);
                        if (wr_cnt_q == '0) begin
                            lim_q <= rows_eff;
                        end
                        if (wr_cnt_q == lim_cur - CW'(1)) begin
                            state_q <= FULL;
                            full_q  <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (storing_i) begin
                        state_q  <= DRAIN;
                        rd_cnt_q <= '0;
                        valid_q  <= 1'b1;
                        last_q   <= (lim_q == CW'(1));
                    end
                end
                DRAIN: begin
                    if (out_ready_i) begin
                        if (last_q) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            full_q  <= 1'b0;
                            empty_q <= 1'b1;
                        end else begin
                            rd_cnt_q <= rd_cnt_q + CW'(1);
                            last_q   <= (rd_cnt_q + CW'(1)
                                         == lim_q - CW'(1));
                        end
                    end
                end
                DONE: begin
                    state_q  <= FILL;
                    empty_q  <= 1'b0;
                    wr_cnt_q <= '0;
                    rd_cnt_q <= '0;
                end
            endcase
        end
    end

    assign out_valid_o  = valid_q;
    assign out_last_o   = last_q;
    assign overflow_o   = ovf_q;
    assign flgs_o.full  = full_q;
    assign flgs_o.empty = empty_q;

endmodule

// File: tb/tb_redmule_zbuf_ctrl.sv
// Self-checking bench for redmule_zbuf_ctrl: randomized rows checked
// against a queue model of the tile contents and the tile-size rule.
module tb_redmule_zbuf_ctrl;
    import redmule_pkg::*;

    localparam int W  = 8;
    localparam int RW = 64;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          clk_en_i = 1'b0;
    logic          fill_i = 1'b0;
    logic [RW-1:0] fill_data_i = '0;
    logic [CW-1:0] rows_i = '0;
    logic          storing_i = 1'b0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [RW-1:0] out_data_o;
    logic          out_last_o;
    z_buffer_flgs_t flgs_o;
    logic          overflow_o;

    int checks = 0;
    int passed = 0;
    logic [RW-1:0] exp_q [$];
    int lim_m = 0;

    redmule_zbuf_ctrl dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .clk_en_i    (clk_en_i),
        .fill_i      (fill_i),
        .fill_data_i (fill_data_i),
        .rows_i      (rows_i),
        .storing_i   (storing_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .flgs_o      (flgs_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [RW-1:0] obs,
                       input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, out_valid_o, 0);
        chk({tag, "_full"}, flgs_o.full, 0);
        chk({tag, "_empty"}, flgs_o.empty, 0);
        chk({tag, "_last"}, out_last_o, 0);
        chk({tag, "_data"}, out_data_o, 0);
        chk({tag, "_ovf"}, overflow_o, 0);
    endtask

    task automatic fill_tile(input int rows, input int n_gated);
        logic [RW-1:0] d;
        lim_m = (rows == 0 || rows > W) ? W : rows;
        exp_q.delete();
        rows_i = CW'(rows);
        for (int k = 0; k < lim_m; k++) begin
            if (k < n_gated) begin
                fill_i = 1'b1;
                clk_en_i = 1'b0;
                fill_data_i = {$urandom(), $urandom()};
                tick();
                chk("gated_full", flgs_o.full, 0);
                chk("gated_ovf", overflow_o, 0);
            end
            d = {$urandom(), $urandom()};
            fill_i = 1'b1;
            clk_en_i = 1'b1;
            fill_data_i = d;
            exp_q.push_back(d);
            tick();
            rows_i = CW'($urandom_range(0, 15));
            chk("fill_full", flgs_o.full, (k == lim_m - 1) ? 1 : 0);
            chk("fill_valid", out_valid_o, 0);
        end
        fill_i = 1'b0;
        clk_en_i = $urandom_range(0, 1);
    endtask

    task automatic drain(input int mode, input int clear_at);
        int idx = 0;
        int cyc = 0;
        logic hs;
        logic [3:0] pat = 4'b1001;
        storing_i = 1'b1;
        out_ready_i = 1'b0;
        tick();
        chk("first_valid", out_valid_o, 1);
        if (mode == 2) storing_i = 1'b0;
        while (idx < lim_m && cyc < 64) begin
            case (mode)
                0: hs = 1'b1;
                1: hs = pat[3 - (cyc % 4)];
                default: hs = 1'($urandom_range(0, 1));
            endcase
            out_ready_i = hs;
            chk("beat_valid", out_valid_o, 1);
            chk("beat_data", out_data_o, exp_q[idx]);
            chk("beat_last", out_last_o, (idx == lim_m - 1) ? 1 : 0);
            chk("beat_full", flgs_o.full, 1);
            chk("beat_empty", flgs_o.empty, 0);
            if (clear_at >= 0 && idx == clear_at) begin
                clear_i = 1'b1;
                tick();
                clear_i = 1'b0;
                storing_i = 1'b0;
                out_ready_i = 1'b0;
                chk_idle("clr");
                tick();
                chk_idle("clr2");
                return;
            end
            tick();
            cyc++;
            if (hs) idx++;
        end
        out_ready_i = 1'b0;
        storing_i = 1'b0;
        if (cyc >= 64) begin
            chk("drain_timeout", 1, 0);
        end else begin
            chk("done_empty", flgs_o.empty, 1);
            chk("done_full", flgs_o.full, 0);
            chk("done_valid", out_valid_o, 0);
            tick();
            chk("post_empty", flgs_o.empty, 0);
            chk("post_valid", out_valid_o, 0);
        end
    endtask

    initial begin
        tick();
        tick();
        chk_idle("reset");
        #2 rst_ni = 1'b1;
        tick();
        chk_idle("post_reset");

        // Full tile, edge tiles, out-of-range sizes.
        fill_tile(8, 0);
        drain(0, -1);
        fill_tile(3, 0);
        drain(0, -1);
        fill_tile(0, 0);
        drain(2, -1);
        fill_tile(12, 0);
        drain(0, -1);

        // Backpressure 1,0,0,1.
        fill_tile(8, 0);
        drain(1, -1);

        // Gated fills, then overflow while FULL.
        fill_tile(5, 3);
        fill_i = 1'b1;
        clk_en_i = 1'b0;
        fill_data_i = {$urandom(), $urandom()};
        tick();
        chk("ovf_gated", overflow_o, 0);
        clk_en_i = 1'b1;
        tick();
        chk("ovf_pulse", overflow_o, 1);
        chk("ovf_full", flgs_o.full, 1);
        fill_i = 1'b0;
        tick();
        chk("ovf_drop", overflow_o, 0);
        drain(0, -1);

        // Clear at beat 4, then a clean tile.
        fill_tile(8, 0);
        drain(0, 4);
        fill_tile(6, 0);
        drain(0, -1);

        // Async reset while FULL.
        fill_tile(8, 0);
        chk("pre_rst_full", flgs_o.full, 1);
        rst_ni = 1'b0;
        #1;
        chk_idle("async_rst");
        #2 rst_ni = 1'b1;
        tick();
        chk_idle("rst_recover");
        fill_tile(4, 0);
        drain(2, -1);

        // Random tiles.
        repeat (6) begin
            fill_tile($urandom_range(0, 12), $urandom_range(0, 2));
            drain($urandom_range(0, 2), -1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
